// File: rtl/mux_scanner.sv
// mux_scanner: registered N:1 channel multiplexer with manual select and an
// auto-scan mode that dwells DWELL enabled cycles on each channel in turn.
module mux_scanner #(
  parameter  int WIDTH  = 4,
  parameter  int NUM_CH = 16,
  parameter  int DWELL  = 4,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*WIDTH-1:0] in,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    mode,
  input  logic                    en,
  output logic [WIDTH-1:0]        out,
  output logic                    out_valid,
  output logic [SEL_W-1:0]        ch,
  output logic                    wrap
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } state_t;

  state_t                        state;
  logic [CNT_W-1:0]              cnt;
  logic [SEL_W-1:0]              ptr;
  logic [NUM_CH-1:0][WIDTH-1:0]  ch_data;

  logic [SEL_W-1:0]              scan_ptr;
  logic [CNT_W-1:0]              scan_cnt;
  logic                          dwell_done;
  logic                          ptr_last;

  // Unpack the flat input bus into per-channel slices (channel 0 = LSBs).
  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign ch_data[k] = in[k*WIDTH +: WIDTH];
  end

  // Effective scan position: entering scan from manual always starts a fresh
  // pass at channel 0, whatever ptr/cnt happen to hold.
  always_comb begin
    scan_ptr   = (state == SCAN) ? ptr : '0;
    scan_cnt   = (state == SCAN) ? cnt : '0;
    dwell_done = (scan_cnt == CNT_W'(DWELL - 1));
    ptr_last   = (scan_ptr == {SEL_W{1'b1}});
  end

  // Mode tracking, sampling, dwell/pointer advance and the wrap pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= MANUAL;
      cnt       <= '0;
      ptr       <= '0;
      out       <= '0;
      ch        <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      state     <= mode ? SCAN : MANUAL;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
      if (!mode) begin
        // Manual: scan position is discarded so a later scan entry is clean.
        cnt <= '0;
        ptr <= '0;
        if (en) begin
          out       <= ch_data[sel];
          ch        <= sel;
          out_valid <= 1'b1;
        end
      end else if (en) begin
        out       <= ch_data[scan_ptr];
        ch        <= scan_ptr;
        out_valid <= 1'b1;
        if (dwell_done) begin
          // Power-of-two channel count: the increment wraps to 0 naturally.
          cnt  <= '0;
          ptr  <= scan_ptr + 1'b1;
          wrap <= ptr_last;
        end else begin
          cnt <= scan_cnt + 1'b1;
          ptr <= scan_ptr;
        end
      end else begin
        // Stalled: hold position, but a stalled scan entry still starts at 0.
        cnt <= scan_cnt;
        ptr <= scan_ptr;
      end
    end
  end

endmodule

// File: tb/tb_mux_scanner.sv
// tb_mux_scanner: directed vector table, randomized run against a pass-index
// reference model, and a 1-bit/16-channel/dwell-1 sweep on a second instance.
module tb_mux_scanner;

  localparam int W = 4;
  localparam int N = 4;
  localparam int D = 2;
  localparam logic [15:0] DIN = 16'hD2A7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Main instance
  logic             rst, mode, en;
  logic [1:0]       sel;
  logic [N*W-1:0]   din;
  logic [W-1:0]     out;
  logic             out_valid, wrap;
  logic [1:0]       ch;

  mux_scanner #(.WIDTH(W), .NUM_CH(N), .DWELL(D)) dut (
    .clk(clk), .rst(rst), .in(din), .sel(sel), .mode(mode), .en(en),
    .out(out), .out_valid(out_valid), .ch(ch), .wrap(wrap)
  );

  // Sweep instance
  logic        rst16, mode16, en16;
  logic [3:0]  sel16;
  logic [15:0] in16;
  logic        out16, valid16, wrap16;
  logic [3:0]  ch16;

  mux_scanner #(.WIDTH(1), .NUM_CH(16), .DWELL(1)) dut16 (
    .clk(clk), .rst(rst16), .in(in16), .sel(sel16), .mode(mode16), .en(en16),
    .out(out16), .out_valid(valid16), .ch(ch16), .wrap(wrap16)
  );

  // Reference model: k counts enabled scan samples since the pass began.
  int       m_k;
  bit       m_scan;
  logic [3:0] m_out;
  bit       m_valid, m_wrap;
  int       m_ch;

  task automatic model_step();
    logic [15:0] d;
    int c;
    d = din;
    m_valid = 0;
    m_wrap  = 0;
    if (rst) begin
      m_k = 0; m_scan = 0; m_out = 0; m_ch = 0;
    end else begin
      if (!mode) begin
        m_k = 0;
        if (en) begin
          m_out = d[int'(sel)*W +: W];
          m_ch = int'(sel);
          m_valid = 1;
        end
      end else begin
        if (!m_scan) m_k = 0;
        if (en) begin
          c = (m_k / D) % N;
          m_out = d[c*W +: W];
          m_ch = c;
          m_valid = 1;
          m_wrap = ((m_k % (D*N)) == D*N - 1);
          m_k++;
        end
      end
      m_scan = mode;
    end
  endtask

  task automatic step(input logic r, m, e, input logic [1:0] s, input logic [15:0] d);
    rst = r; mode = m; en = e; sel = s; din = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [3:0] eo, input logic ev,
                       input logic [1:0] ec, input logic ew);
    checks++;
    if (out !== eo || out_valid !== ev || ch !== ec || wrap !== ew) begin
      errors++;
      $display("FAIL %s: got out=%h valid=%b ch=%0d wrap=%b, want out=%h valid=%b ch=%0d wrap=%b",
               name, out, out_valid, ch, wrap, eo, ev, ec, ew);
    end
  endtask

  typedef struct {
    logic       r, m, e;
    logic [1:0] s;
    logic [3:0] eo;
    logic       ev;
    logic [1:0] ec;
    logic       ew;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, m, e, input logic [1:0] s,
                     input logic [3:0] eo, input logic ev, input logic [1:0] ec, input logic ew);
    vec_t v;
    v.r = r; v.m = m; v.e = e; v.s = s; v.eo = eo; v.ev = ev; v.ec = ec; v.ew = ew;
    vq.push_back(v);
  endtask

  initial begin
    logic [15:0] rnd_in;
    logic [15:0] tmp;
    int idx;
    rst = 1; mode = 0; en = 0; sel = 0; din = DIN;
    rst16 = 1; mode16 = 1; en16 = 0; sel16 = 0; in16 = 0;
    m_k = 0; m_scan = 0; m_out = 0; m_valid = 0; m_wrap = 0; m_ch = 0;

    //  r  m  e  sel  out  v  ch wrap
    add(1, 1, 1, 3, 4'h0, 0, 0, 0);   // reset wins over mode/en
    add(0, 0, 1, 2, 4'h2, 1, 2, 0);   // manual sel=2
    add(0, 0, 1, 3, 4'hD, 1, 3, 0);   // manual sel=3
    add(0, 0, 0, 0, 4'hD, 0, 3, 0);   // manual stall holds
    add(0, 0, 1, 0, 4'h7, 1, 0, 0);   // manual sel=0
    add(1, 0, 0, 0, 4'h0, 0, 0, 0);   // reset
    add(0, 1, 1, 0, 4'h7, 1, 0, 0);   // scan pass
    add(0, 1, 1, 0, 4'h7, 1, 0, 0);
    add(0, 1, 1, 0, 4'hA, 1, 1, 0);
    add(0, 1, 1, 0, 4'hA, 1, 1, 0);
    add(0, 1, 1, 0, 4'h2, 1, 2, 0);
    add(0, 1, 1, 0, 4'h2, 1, 2, 0);
    add(0, 1, 1, 0, 4'hD, 1, 3, 0);
    add(0, 1, 1, 0, 4'hD, 1, 3, 1);   // pass complete
    add(0, 1, 1, 0, 4'h7, 1, 0, 0);
    add(0, 1, 1, 0, 4'h7, 1, 0, 0);
    add(0, 1, 1, 0, 4'hA, 1, 1, 0);   // first A
    add(0, 1, 0, 0, 4'hA, 0, 1, 0);   // stall x3
    add(0, 1, 0, 0, 4'hA, 0, 1, 0);
    add(0, 1, 0, 0, 4'hA, 0, 1, 0);
    add(0, 1, 1, 0, 4'hA, 1, 1, 0);   // second A
    add(0, 1, 1, 0, 4'h2, 1, 2, 0);   // scanning at ch2
    add(0, 0, 1, 1, 4'hA, 1, 1, 0);   // to manual sel=1
    add(0, 1, 1, 0, 4'h7, 1, 0, 0);   // back to scan restarts at ch0
    add(0, 1, 1, 0, 4'h7, 1, 0, 0);
    add(0, 1, 1, 0, 4'hA, 1, 1, 0);
    add(0, 1, 1, 0, 4'hA, 1, 1, 0);
    add(0, 1, 1, 0, 4'h2, 1, 2, 0);
    add(0, 1, 1, 0, 4'h2, 1, 2, 0);
    add(0, 1, 1, 0, 4'hD, 1, 3, 0);   // ch3 dwell
    add(1, 1, 1, 0, 4'h0, 0, 0, 0);   // reset mid-dwell, no wrap
    add(0, 1, 1, 0, 4'h7, 1, 0, 0);   // restart at ch0
    add(0, 1, 1, 0, 4'h7, 1, 0, 0);
    add(0, 1, 0, 0, 4'h7, 0, 0, 0);   // stall
    add(0, 0, 0, 0, 4'h7, 0, 0, 0);   // to manual while stalled
    add(0, 1, 1, 0, 4'h7, 1, 0, 0);   // stalled exit still restarts at ch0
    add(0, 1, 1, 0, 4'h7, 1, 0, 0);
    add(0, 1, 1, 0, 4'hA, 1, 1, 0);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].r, vq[i].m, vq[i].e, vq[i].s, DIN);
      check($sformatf("vec%0d", i), vq[i].eo, vq[i].ev, vq[i].ec, vq[i].ew);
    end

    // Randomized run against the model
    step(1, 0, 0, 0, DIN);
    check("rand_reset", 4'h0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      logic r, m, e;
      r = ($urandom_range(0, 39) == 0);
      m = ($urandom_range(0, 7) == 0) ? ~mode : mode;
      e = ($urandom_range(0, 3) != 0);
      rnd_in = 16'($urandom);
      step(r, m, e, 2'($urandom), rnd_in);
      check($sformatf("rand%0d", i), m_out, m_valid, 2'(m_ch), m_wrap);
    end

    // Sweep: 1-bit, 16 channels, dwell 1
    rst16 = 1; en16 = 1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (out16 !== 1'b0 || valid16 !== 1'b0 || ch16 !== 4'd0 || wrap16 !== 1'b0) begin
      errors++;
      $display("FAIL sweep_reset: got out=%b valid=%b ch=%0d wrap=%b, want 0 0 0 0",
               out16, valid16, ch16, wrap16);
    end
    rst16 = 0;
    for (int j = 0; j < 40; j++) begin
      in16 = 16'($urandom);
      tmp  = in16;
      idx  = j % 16;
      @(posedge clk); @(negedge clk);
      checks++;
      if (out16 !== tmp[idx] || valid16 !== 1'b1 || ch16 !== 4'(idx) ||
          wrap16 !== (idx == 15)) begin
        errors++;
        $display("FAIL sweep%0d: got out=%b valid=%b ch=%0d wrap=%b, want out=%b valid=1 ch=%0d wrap=%b",
                 j, out16, valid16, ch16, wrap16, tmp[idx], idx, (idx == 15));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
